// File: rtl/agu_data_sequencer.sv
// Radix-2 DIT FFT butterfly operand address generator: emits (A, B, stage) per butterfly in twiddle-sequencer order.
// Counters run one edge ahead of the registered outputs; stall freezes both while a butterfly is presented.
module agu_data_sequencer #(
  parameter int LOG_N = 4,
  parameter int SW    = 3
) (
  input  logic             pulse,
  input  logic             reset,
  input  logic             c_aSeq_start,
  input  logic             stall,
  output logic [LOG_N-1:0] addrA,
  output logic [LOG_N-1:0] addrB,
  output logic [SW-1:0]    stage_out,
  output logic             bfly_valid,
  output logic             bfly_last,
  output logic             done
);

  localparam int JW = LOG_N - 1;
  localparam logic [JW-1:0] J_LAST     = '1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(LOG_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     stage, stage_nxt;
  logic [JW-1:0]     j, j_nxt;
  logic [LOG_N-1:0]  a_nxt, b_nxt;
  logic [SW-1:0]     so_nxt;
  logic              v_nxt, l_nxt, d_nxt;
  logic [LOG_N-1:0]  jx, lo_mask, addr_a, addr_b;
  logic              hold;

  // A is j with a zero inserted at bit 'stage'; B sets that bit.
  always_comb begin
    jx      = {1'b0, j};
    lo_mask = ~({LOG_N{1'b1}} << stage);
    addr_a  = ((jx & ~lo_mask) << 1) | (jx & lo_mask);
    addr_b  = addr_a | ({{(LOG_N-1){1'b0}}, 1'b1} << stage);
  end

  // Stall only matters while a butterfly is on the outputs, so the final
  // butterfly is held too and done slips by the stall length.
  assign hold = stall & bfly_valid;

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    j_nxt     = j;
    a_nxt     = addrA;
    b_nxt     = addrB;
    so_nxt    = stage_out;
    v_nxt     = bfly_valid;
    l_nxt     = bfly_last;
    d_nxt     = done;
    if (!hold) begin
      a_nxt  = '0;
      b_nxt  = '0;
      so_nxt = '0;
      v_nxt  = 1'b0;
      l_nxt  = 1'b0;
      d_nxt  = 1'b0;
      case (state)
        S_IDLE: begin
          if (c_aSeq_start) begin
            state_nxt = S_RUN;
            stage_nxt = '0;
            j_nxt     = '0;
          end
        end
        S_RUN: begin
          a_nxt  = addr_a;
          b_nxt  = addr_b;
          so_nxt = stage;
          v_nxt  = 1'b1;
          l_nxt  = (j == J_LAST);
          if (j != J_LAST) begin
            j_nxt = j + 1'b1;
          end else begin
            j_nxt = '0;
            if (stage == STAGE_LAST) state_nxt = S_DONE;
            else                     stage_nxt = stage + 1'b1;
          end
        end
        S_DONE: begin
          d_nxt     = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pulse) begin
    if (reset) begin
      state      <= S_IDLE;
      stage      <= '0;
      j          <= '0;
      addrA      <= '0;
      addrB      <= '0;
      stage_out  <= '0;
      bfly_valid <= 1'b0;
      bfly_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      stage      <= stage_nxt;
      j          <= j_nxt;
      addrA      <= a_nxt;
      addrB      <= b_nxt;
      stage_out  <= so_nxt;
      bfly_valid <= v_nxt;
      bfly_last  <= l_nxt;
      done       <= d_nxt;
    end
  end

endmodule

// File: tb/tb_agu_data_sequencer.sv
// Directed bench for agu_data_sequencer (N=16): vector table plus hand-built stall/restart/reset sequences.
module tb_agu_data_sequencer;
  logic       pulse, reset, c_aSeq_start, stall;
  logic [3:0] addrA, addrB;
  logic [2:0] stage_out;
  logic       bfly_valid, bfly_last, done;

  agu_data_sequencer #(.LOG_N(4), .SW(3)) dut (
    .pulse(pulse), .reset(reset), .c_aSeq_start(c_aSeq_start), .stall(stall),
    .addrA(addrA), .addrB(addrB), .stage_out(stage_out),
    .bfly_valid(bfly_valid), .bfly_last(bfly_last), .done(done)
  );

  initial pulse = 1'b0;
  always #5 pulse = ~pulse;

  typedef struct {
    int ed; int a; int b; int s; int v; int l; int d;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [3:0] ca [0:63];
  logic [3:0] cb [0:63];
  logic [2:0] cs [0:63];
  logic       cv [0:63];
  logic       cl [0:63];
  logic       cd [0:63];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; c_aSeq_start = 1'b0; stall = 1'b0;
    @(posedge pulse); #1;
    reset = 1'b0;
  endtask

  // Edge e samples the inputs driven just before it; outputs captured #1 after it.
  task automatic do_run(input int nedges, input int st_at, input int st_len,
                        input int xs1, input int xs2, input int xs3);
    for (int e = 0; e < nedges; e++) begin
      c_aSeq_start = (e == 0) || (e == xs1) || (e == xs2) || (e == xs3);
      stall        = (e >= st_at) && (e < st_at + st_len);
      @(posedge pulse); #1;
      ca[e] = addrA; cb[e] = addrB; cs[e] = stage_out;
      cv[e] = bfly_valid; cl[e] = bfly_last; cd[e] = done;
    end
    c_aSeq_start = 1'b0;
    stall        = 1'b0;
  endtask

  // Stall-free run: butterfly n at edge n+1, stage n/8, j n%8.
  task automatic chk_model(input string tag);
    int s, jj, ea, tw_ref, tw_dut, p, dups;
    int seen [0:3];
    dups = 0;
    for (int k = 0; k < 4; k++) seen[k] = 0;
    for (int n = 0; n < 32; n++) begin
      s  = n / 8;
      jj = n % 8;
      ea = (jj / (1 << s)) * (2 << s) + jj % (1 << s);
      chk($sformatf("%s A e%0d", tag, n + 1), int'(ca[n+1]), ea);
      chk($sformatf("%s B-A e%0d", tag, n + 1), int'(cb[n+1]) - int'(ca[n+1]), 1 << int'(cs[n+1]));
      chk($sformatf("%s stage e%0d", tag, n + 1), int'(cs[n+1]), s);
      chk($sformatf("%s valid e%0d", tag, n + 1), int'(cv[n+1]), 1);
      chk($sformatf("%s last e%0d", tag, n + 1), int'(cl[n+1]), (jj == 7) ? 1 : 0);
      chk($sformatf("%s done e%0d", tag, n + 1), int'(cd[n+1]), 0);
      p      = int'(ca[n+1]) % (1 << int'(cs[n+1]));
      tw_dut = p * (16 >> (int'(cs[n+1]) + 1));
      tw_ref = (jj % (1 << s)) * (8 >> s);
      chk($sformatf("%s twiddle e%0d", tag, n + 1), tw_dut, tw_ref);
      if (cs[n+1] < 3'd4) begin
        if (seen[cs[n+1]][ca[n+1]] || seen[cs[n+1]][cb[n+1]]) dups++;
        seen[cs[n+1]] = seen[cs[n+1]] | (1 << int'(ca[n+1])) | (1 << int'(cb[n+1]));
      end
    end
    chk($sformatf("%s duplicate addrs", tag), dups, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("%s cover stage%0d", tag, k), seen[k], 16'hFFFF);
  endtask

  vec_t tbl [0:12];
  int   dcount;

  initial begin
    tbl[0]  = '{1, 0, 1, 0, 1, 0, 0};
    tbl[1]  = '{2, 2, 3, 0, 1, 0, 0};
    tbl[2]  = '{8, 14, 15, 0, 1, 1, 0};
    tbl[3]  = '{9, 0, 2, 1, 1, 0, 0};
    tbl[4]  = '{10, 1, 3, 1, 1, 0, 0};
    tbl[5]  = '{11, 4, 6, 1, 1, 0, 0};
    tbl[6]  = '{12, 5, 7, 1, 1, 0, 0};
    tbl[7]  = '{17, 0, 4, 2, 1, 0, 0};
    tbl[8]  = '{25, 0, 8, 3, 1, 0, 0};
    tbl[9]  = '{26, 1, 9, 3, 1, 0, 0};
    tbl[10] = '{32, 7, 15, 3, 1, 1, 0};
    tbl[11] = '{33, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{34, 0, 0, 0, 0, 0, 0};

    // Reset state
    do_reset();
    chk("rst addrA", int'(addrA), 0);
    chk("rst addrB", int'(addrB), 0);
    chk("rst valid", int'(bfly_valid), 0);
    chk("rst done", int'(done), 0);

    // Plain run: table vectors plus full model sweep
    do_run(40, -1, 0, -1, -1, -1);
    for (int i = 0; i <= 12; i++) begin
      chk($sformatf("t1 A e%0d", tbl[i].ed), int'(ca[tbl[i].ed]), tbl[i].a);
      chk($sformatf("t1 B e%0d", tbl[i].ed), int'(cb[tbl[i].ed]), tbl[i].b);
      chk($sformatf("t1 stage e%0d", tbl[i].ed), int'(cs[tbl[i].ed]), tbl[i].s);
      chk($sformatf("t1 valid e%0d", tbl[i].ed), int'(cv[tbl[i].ed]), tbl[i].v);
      chk($sformatf("t1 last e%0d", tbl[i].ed), int'(cl[tbl[i].ed]), tbl[i].l);
      chk($sformatf("t1 done e%0d", tbl[i].ed), int'(cd[tbl[i].ed]), tbl[i].d);
    end
    chk_model("t6");
    dcount = 0;
    for (int e = 0; e < 40; e++) dcount += int'(cd[e]);
    chk("t1 done count", dcount, 1);

    // Stall three edges while (4,6) is presented
    do_reset();
    do_run(40, 12, 3, -1, -1, -1);
    for (int e = 11; e <= 14; e++) begin
      chk($sformatf("t3 A hold e%0d", e), int'(ca[e]), 4);
      chk($sformatf("t3 B hold e%0d", e), int'(cb[e]), 6);
      chk($sformatf("t3 valid hold e%0d", e), int'(cv[e]), 1);
    end
    chk("t3 A after", int'(ca[15]), 5);
    chk("t3 B after", int'(cb[15]), 7);
    chk("t3 last final", int'(cl[35]), 1);
    chk("t3 B final", int'(cb[35]), 15);
    chk("t3 done e33", int'(cd[33]), 0);
    chk("t3 done e36", int'(cd[36]), 1);
    chk("t3 valid e36", int'(cv[36]), 0);

    // Extra starts mid-run and in DONE are ignored; start in IDLE restarts
    do_reset();
    do_run(37, -1, 0, 5, 33, 34);
    chk_model("t4");
    chk("t4 done e33", int'(cd[33]), 1);
    chk("t4 valid e34", int'(cv[34]), 0);
    chk("t4 restart valid e35", int'(cv[35]), 1);
    chk("t4 restart A e35", int'(ca[35]), 0);
    chk("t4 restart B e35", int'(cb[35]), 1);

    // Reset mid stage 1 with stall held
    do_reset();
    do_run(12, -1, 0, -1, -1, -1);
    chk("t5 pre A e11", int'(ca[11]), 4);
    reset = 1'b1; stall = 1'b1;
    @(posedge pulse); #1;
    chk("t5 rst A", int'(addrA), 0);
    chk("t5 rst B", int'(addrB), 0);
    chk("t5 rst stage", int'(stage_out), 0);
    chk("t5 rst valid", int'(bfly_valid), 0);
    chk("t5 rst last", int'(bfly_last), 0);
    chk("t5 rst done", int'(done), 0);
    reset = 1'b0;
    dcount = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge pulse); #1;
      dcount += int'(done) + int'(bfly_valid);
    end
    chk("t5 idle after reset", dcount, 0);
    do_run(2, 0, 2, -1, -1, -1);
    chk("t5 restart valid", int'(cv[1]), 1);
    chk("t5 restart A", int'(ca[1]), 0);
    chk("t5 restart B", int'(cb[1]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
